// File: rtl/axi_traffic_gen_pkg.sv
// Shared types and the data pattern for the AXI traffic generator and its responder models.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi_traffic_gen_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Byte address of beat j of burst k. The caller truncates the result to
    // its own address width, so wrap-around follows the bus width.
    function automatic logic [63:0] beat_address(
        input logic [63:0] base,
        input logic [15:0] k,
        input logic [7:0]  len,
        input logic [7:0]  j,
        input logic [15:0] bytes_per_beat
    );
        return base + ((64'(k) * (64'(len) + 64'd1)) + 64'(j)) * 64'(bytes_per_beat);
    endfunction

    // One 64-bit lane of beat data: the beat's own byte address. The full
    // beat is this word replicated across the data bus.
    function automatic logic [63:0] pattern_word(input logic [63:0] addr);
        return addr;
    endfunction

    // Saturating add used by the error counter; it never wraps back to zero.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/axi_traffic_gen.sv
// AXI4 write-then-read-back traffic generator with a data checker and an error counter.
// Latency: one cycle per FSM step; done rises two edges after a zero-burst start.
// Backpressure: one channel active at a time; every VALID holds until its READY.
//
// Ports: clk/resetn (sync, active-low); start/base_addr/burst_count/burst_len
// are sampled together in IDLE; busy/done/error_count report status.
// M_AXI_* is a single-ID AXI4 master: the AW/W/B write path, then the AR/R read path.
module axi_traffic_gen
    import axi_traffic_gen_pkg::*;
#(
    parameter int DW = 512,
    parameter int AW = 64
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [AW-1:0]   base_addr,
    input  logic [15:0]     burst_count,
    input  logic [7:0]      burst_len,
    output logic            busy,
    output logic            done,
    output logic [31:0]     error_count,
    output logic [AW-1:0]   M_AXI_AWADDR,
    output logic [7:0]      M_AXI_AWLEN,
    output logic [2:0]      M_AXI_AWSIZE,
    output logic [1:0]      M_AXI_AWBURST,
    output logic            M_AXI_AWVALID,
    input  logic            M_AXI_AWREADY,
    output logic [DW-1:0]   M_AXI_WDATA,
    output logic [DW/8-1:0] M_AXI_WSTRB,
    output logic            M_AXI_WLAST,
    output logic            M_AXI_WVALID,
    input  logic            M_AXI_WREADY,
    input  logic [1:0]      M_AXI_BRESP,
    input  logic            M_AXI_BVALID,
    output logic            M_AXI_BREADY,
    output logic [AW-1:0]   M_AXI_ARADDR,
    output logic [7:0]      M_AXI_ARLEN,
    output logic [2:0]      M_AXI_ARSIZE,
    output logic [1:0]      M_AXI_ARBURST,
    output logic            M_AXI_ARVALID,
    input  logic            M_AXI_ARREADY,
    input  logic [DW-1:0]   M_AXI_RDATA,
    input  logic [1:0]      M_AXI_RRESP,
    input  logic            M_AXI_RLAST,
    input  logic            M_AXI_RVALID,
    output logic            M_AXI_RREADY
);

    localparam int         BYTES  = DW / 8;
    localparam int         WORDS  = DW / 64;
    localparam logic [2:0] AXSIZE = 3'($clog2(BYTES));

    state_t        state, state_nxt;
    logic [AW-1:0] base_q;
    logic [AW-1:0] burst_addr;   // A(k): start address of the current burst
    logic [AW-1:0] beat_addr;    // A(k) + j*BYTES: address of the current beat
    logic [15:0]   count_q;
    logic [15:0]   k;
    logic [7:0]    len_q;
    logic [7:0]    j;
    logic [31:0]   err_q;
    logic          done_q;

    logic          last_beat;
    logic          last_burst;
    logic [AW-1:0] burst_bytes;
    logic [DW-1:0] exp_data;
    logic [1:0]    r_err;

    logic aw_vld, w_vld, b_rdy, ar_vld, r_rdy;

    assign last_beat   = (j == len_q);
    assign last_burst  = ({1'b0, k} + 17'd1) == {1'b0, count_q};
    assign burst_bytes = AW'((64'(len_q) + 64'd1) * 64'(BYTES));
    assign exp_data    = {WORDS{pattern_word(64'(beat_addr))}};

    // A read beat can carry up to three independent faults, each counted.
    always_comb begin
        r_err = 2'd0;
        r_err = 2'(M_AXI_RDATA != exp_data) + 2'(M_AXI_RRESP != RESP_OKAY)
              + 2'(M_AXI_RLAST != last_beat);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        aw_vld    = 1'b0;
        w_vld     = 1'b0;
        b_rdy     = 1'b0;
        ar_vld    = 1'b0;
        r_rdy     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (burst_count == 16'd0) ? S_DONE : S_AW;
                end
            end
            S_AW: begin
                aw_vld = 1'b1;
                if (M_AXI_AWREADY) state_nxt = S_W;
            end
            S_W: begin
                w_vld = 1'b1;
                if (M_AXI_WREADY && last_beat) state_nxt = S_B;
            end
            S_B: begin
                b_rdy = 1'b1;
                if (M_AXI_BVALID) state_nxt = last_burst ? S_AR : S_AW;
            end
            S_AR: begin
                ar_vld = 1'b1;
                if (M_AXI_ARREADY) state_nxt = S_R;
            end
            S_R: begin
                r_rdy = 1'b1;
                // RLAST is only checked; the beat count alone ends the burst.
                if (M_AXI_RVALID && last_beat) state_nxt = last_burst ? S_DONE : S_AR;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            base_q     <= '0;
            burst_addr <= '0;
            beat_addr  <= '0;
            count_q    <= '0;
            len_q      <= '0;
            k          <= '0;
            j          <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            // Registered so the pulse is a clean flop output, one cycle after DONE.
            done_q <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        count_q    <= burst_count;
                        len_q      <= burst_len;
                        burst_addr <= base_addr;
                        beat_addr  <= base_addr;
                        k          <= '0;
                        j          <= '0;
                        err_q      <= '0;
                    end
                end
                S_AW: begin
                    if (M_AXI_AWREADY) begin
                        j         <= '0;
                        beat_addr <= burst_addr;
                    end
                end
                S_W: begin
                    if (M_AXI_WREADY) begin
                        j         <= j + 8'd1;
                        beat_addr <= beat_addr + AW'(BYTES);
                    end
                end
                S_B: begin
                    if (M_AXI_BVALID) begin
                        err_q <= sat_add(err_q, {1'b0, M_AXI_BRESP != RESP_OKAY});
                        if (last_burst) begin
                            // Write phase over: rewind to burst 0 for read-back.
                            k          <= '0;
                            burst_addr <= base_q;
                        end else begin
                            k          <= k + 16'd1;
                            burst_addr <= burst_addr + burst_bytes;
                        end
                    end
                end
                S_AR: begin
                    if (M_AXI_ARREADY) begin
                        j         <= '0;
                        beat_addr <= burst_addr;
                    end
                end
                S_R: begin
                    if (M_AXI_RVALID) begin
                        err_q     <= sat_add(err_q, r_err);
                        j         <= j + 8'd1;
                        beat_addr <= beat_addr + AW'(BYTES);
                        if (last_beat) begin
                            k          <= k + 16'd1;
                            burst_addr <= burst_addr + burst_bytes;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (state != S_IDLE) && (state != S_DONE);
    assign done        = done_q;
    assign error_count = err_q;

    assign M_AXI_AWADDR  = burst_addr;
    assign M_AXI_AWLEN   = len_q;
    assign M_AXI_AWSIZE  = AXSIZE;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWVALID = aw_vld;
    assign M_AXI_WDATA   = exp_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = last_beat;
    assign M_AXI_WVALID  = w_vld;
    assign M_AXI_BREADY  = b_rdy;
    assign M_AXI_ARADDR  = burst_addr;
    assign M_AXI_ARLEN   = len_q;
    assign M_AXI_ARSIZE  = AXSIZE;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARVALID = ar_vld;
    assign M_AXI_RREADY  = r_rdy;

endmodule

// File: tb/tb_axi_traffic_gen.sv
// Directed bench for axi_traffic_gen with a configurable single-beat-at-a-time AXI responder.
// Stimulus changes 1 time unit after the rising edge; the responder acts on the falling edge.
module tb_axi_traffic_gen;

    logic         clk;
    logic         resetn;
    logic         start;
    logic [63:0]  base_addr;
    logic [15:0]  burst_count;
    logic [7:0]   burst_len;
    logic         busy;
    logic         done;
    logic [31:0]  error_count;
    logic [63:0]  M_AXI_AWADDR;
    logic [7:0]   M_AXI_AWLEN;
    logic [2:0]   M_AXI_AWSIZE;
    logic [1:0]   M_AXI_AWBURST;
    logic         M_AXI_AWVALID;
    logic         M_AXI_AWREADY;
    logic [511:0] M_AXI_WDATA;
    logic [63:0]  M_AXI_WSTRB;
    logic         M_AXI_WLAST;
    logic         M_AXI_WVALID;
    logic         M_AXI_WREADY;
    logic [1:0]   M_AXI_BRESP;
    logic         M_AXI_BVALID;
    logic         M_AXI_BREADY;
    logic [63:0]  M_AXI_ARADDR;
    logic [7:0]   M_AXI_ARLEN;
    logic [2:0]   M_AXI_ARSIZE;
    logic [1:0]   M_AXI_ARBURST;
    logic         M_AXI_ARVALID;
    logic         M_AXI_ARREADY;
    logic [511:0] M_AXI_RDATA;
    logic [1:0]   M_AXI_RRESP;
    logic         M_AXI_RLAST;
    logic         M_AXI_RVALID;
    logic         M_AXI_RREADY;

    axi_traffic_gen dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .burst_count(burst_count), .burst_len(burst_len), .busy(busy), .done(done),
        .error_count(error_count),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN), .M_AXI_AWSIZE(M_AXI_AWSIZE),
        .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN), .M_AXI_ARSIZE(M_AXI_ARSIZE),
        .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;

    // Responder configuration (written only by the main initial block).
    int aw_delay, w_delay, bad_b, bad_r_burst, bad_r_beat;
    bit early_last;

    // Responder logs and counters (written only by the responder).
    logic [63:0]  aw_log[$];
    logic [7:0]   awlen_log[$];
    logic [2:0]   awsize_log[$];
    logic [1:0]   awburst_log[$];
    logic [511:0] w_log[$];
    logic         wlast_log[$];
    logic [63:0]  wstrb_log[$];
    logic [63:0]  ar_log[$];
    int unstable_cnt, overlap_cnt, active_cnt, done_cnt, r_hs_cnt;

    int aw_wait, w_wait, bcnt, rcnt, r_beat, r_len;
    bit b_pending, r_active;
    logic [63:0]  aw_hold, r_addr;
    logic [511:0] w_hold;

    always @(negedge clk) begin : responder
        int nv;
        logic [63:0]  word;
        logic [511:0] rd;
        nv = int'(M_AXI_AWVALID) + int'(M_AXI_WVALID) + int'(M_AXI_ARVALID)
           + int'(M_AXI_BREADY) + int'(M_AXI_RREADY);
        if (nv > 1) overlap_cnt++;
        if (nv > 0) active_cnt++;
        if (done) done_cnt++;
        if (!resetn) begin
            M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
            M_AXI_BVALID = 0; M_AXI_BRESP = 0;
            M_AXI_RVALID = 0; M_AXI_RLAST = 0; M_AXI_RRESP = 0; M_AXI_RDATA = '0;
            b_pending = 0; r_active = 0; aw_wait = 0; w_wait = 0; bcnt = 0; rcnt = 0;
        end else begin
            if (!busy) begin
                bcnt = 0;
                rcnt = 0;
            end
            // B: respond once after each write burst's last beat.
            if (b_pending) begin
                M_AXI_BVALID = 1;
                M_AXI_BRESP  = (bcnt == bad_b) ? 2'b10 : 2'b00;
                if (M_AXI_BREADY) begin
                    b_pending = 0;
                    bcnt++;
                end
            end else begin
                M_AXI_BVALID = 0;
                M_AXI_BRESP  = 0;
            end
            // W
            if (M_AXI_WVALID) begin
                if (w_wait == 0) w_hold = M_AXI_WDATA;
                else if (M_AXI_WDATA !== w_hold) unstable_cnt++;
                if (w_wait < w_delay) begin
                    M_AXI_WREADY = 0;
                    w_wait++;
                end else begin
                    M_AXI_WREADY = 1;
                    w_wait = 0;
                    w_log.push_back(M_AXI_WDATA);
                    wlast_log.push_back(M_AXI_WLAST);
                    wstrb_log.push_back(M_AXI_WSTRB);
                    if (M_AXI_WLAST) b_pending = 1;
                end
            end else begin
                M_AXI_WREADY = 0;
                w_wait = 0;
            end
            // AW
            if (M_AXI_AWVALID) begin
                if (aw_wait == 0) aw_hold = M_AXI_AWADDR;
                else if (M_AXI_AWADDR !== aw_hold) unstable_cnt++;
                if (aw_wait < aw_delay) begin
                    M_AXI_AWREADY = 0;
                    aw_wait++;
                end else begin
                    M_AXI_AWREADY = 1;
                    aw_wait = 0;
                    aw_log.push_back(M_AXI_AWADDR);
                    awlen_log.push_back(M_AXI_AWLEN);
                    awsize_log.push_back(M_AXI_AWSIZE);
                    awburst_log.push_back(M_AXI_AWBURST);
                end
            end else begin
                M_AXI_AWREADY = 0;
                aw_wait = 0;
            end
            // R: data is the beat address replicated, optionally faulted.
            if (r_active) begin
                word = r_addr + 64'(r_beat) * 64'd64;
                rd   = {8{word}};
                if (rcnt == bad_r_burst && r_beat == bad_r_beat) rd[130] = ~rd[130];
                M_AXI_RVALID = 1;
                M_AXI_RDATA  = rd;
                M_AXI_RRESP  = 0;
                M_AXI_RLAST  = early_last ? (r_beat == r_len - 1) : (r_beat == r_len);
                if (M_AXI_RREADY) begin
                    r_hs_cnt++;
                    if (r_beat == r_len) begin
                        r_active = 0;
                        rcnt++;
                    end else begin
                        r_beat++;
                    end
                end
            end else begin
                M_AXI_RVALID = 0;
                M_AXI_RLAST  = 0;
            end
            // AR
            if (M_AXI_ARVALID) begin
                M_AXI_ARREADY = 1;
                ar_log.push_back(M_AXI_ARADDR);
                r_addr   = M_AXI_ARADDR;
                r_len    = int'(M_AXI_ARLEN);
                r_beat   = 0;
                r_active = 1;
            end else begin
                M_AXI_ARREADY = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                ok = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: done=%0b after 3000 cycles, want 1", name, done);
        end
    endtask

    task automatic run_test(input string name, input logic [63:0] base,
                            input logic [15:0] cnt, input logic [7:0] len);
        base_addr   = base;
        burst_count = cnt;
        burst_len   = len;
        start       = 1;
        tick();
        start = 0;
        wait_done(name);
        tick();
        tick();
    endtask

    task automatic test_reset();
        resetn = 0;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
        checks++; if (error_count !== 32'd0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", error_count); end
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY} !== 5'b0) begin
            errors++;
            $display("FAIL reset_handshake: got %b want 00000",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY});
        end
        resetn = 1;
        tick();
    endtask

    task automatic test_basic();
        int a0, w0, r0, d0, o0;
        a0 = aw_log.size(); w0 = w_log.size(); r0 = ar_log.size(); d0 = done_cnt; o0 = overlap_cnt;
        run_test("basic", 64'h1000, 16'd2, 8'd3);
        checks++; if (aw_log.size() - a0 !== 2) begin errors++; $display("FAIL basic_aw_count: got %0d want 2", aw_log.size() - a0); end
        checks++; if (aw_log[a0] !== 64'h1000) begin errors++; $display("FAIL basic_aw0: got %h want 1000", aw_log[a0]); end
        checks++; if (aw_log[a0+1] !== 64'h1100) begin errors++; $display("FAIL basic_aw1: got %h want 1100", aw_log[a0+1]); end
        checks++; if (awlen_log[a0] !== 8'd3) begin errors++; $display("FAIL basic_awlen: got %0d want 3", awlen_log[a0]); end
        checks++; if (awsize_log[a0] !== 3'd6) begin errors++; $display("FAIL basic_awsize: got %0d want 6", awsize_log[a0]); end
        checks++; if (awburst_log[a0] !== 2'b01) begin errors++; $display("FAIL basic_awburst: got %b want 01", awburst_log[a0]); end
        checks++; if (w_log.size() - w0 !== 8) begin errors++; $display("FAIL basic_w_count: got %0d want 8", w_log.size() - w0); end
        checks++; if (w_log[w0] !== {8{64'h1000}}) begin errors++; $display("FAIL basic_w0: got %h want 8x1000", w_log[w0]); end
        checks++; if (w_log[w0+1] !== {8{64'h1040}}) begin errors++; $display("FAIL basic_w1: got %h want 8x1040", w_log[w0+1]); end
        checks++; if (w_log[w0+4] !== {8{64'h1100}}) begin errors++; $display("FAIL basic_w4: got %h want 8x1100", w_log[w0+4]); end
        checks++; if (wstrb_log[w0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL basic_wstrb: got %h want all ones", wstrb_log[w0]); end
        checks++; if ({wlast_log[w0+2], wlast_log[w0+3]} !== 2'b01) begin errors++; $display("FAIL basic_wlast: got %b want 01", {wlast_log[w0+2], wlast_log[w0+3]}); end
        checks++; if (ar_log.size() - r0 !== 2) begin errors++; $display("FAIL basic_ar_count: got %0d want 2", ar_log.size() - r0); end
        checks++; if (ar_log[r0] !== 64'h1000 || ar_log[r0+1] !== 64'h1100) begin errors++; $display("FAIL basic_araddr: got %h %h want 1000 1100", ar_log[r0], ar_log[r0+1]); end
        checks++; if (error_count !== 32'd0) begin errors++; $display("FAIL basic_errcnt: got %0d want 0", error_count); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (overlap_cnt - o0 !== 0) begin errors++; $display("FAIL basic_overlap: got %0d want 0", overlap_cnt - o0); end
    endtask

    task automatic test_zero();
        int act0;
        act0 = active_cnt;
        base_addr = 64'h2000; burst_count = 16'd0; burst_len = 8'd5; start = 1;
        tick();
        start = 0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_c1: got %0b want 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_c2: got %0b want 1", done); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_c3: got %0b want 0", done); end
        checks++; if (active_cnt - act0 !== 0) begin errors++; $display("FAIL zero_valid_seen: got %0d cycles want 0", active_cnt - act0); end
        checks++; if (error_count !== 32'd0) begin errors++; $display("FAIL zero_errcnt: got %0d want 0", error_count); end
    endtask

    task automatic test_backpressure();
        int a0, w0, u0;
        a0 = aw_log.size(); w0 = w_log.size(); u0 = unstable_cnt;
        aw_delay = 5; w_delay = 5;
        run_test("bp", 64'h1000, 16'd2, 8'd3);
        aw_delay = 0; w_delay = 0;
        checks++; if (unstable_cnt - u0 !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", unstable_cnt - u0); end
        checks++; if (aw_log.size() - a0 !== 2) begin errors++; $display("FAIL bp_aw_count: got %0d want 2", aw_log.size() - a0); end
        checks++; if (w_log.size() - w0 !== 8) begin errors++; $display("FAIL bp_w_count: got %0d want 8", w_log.size() - w0); end
        checks++; if (w_log[w0+7] !== {8{64'h11C0}}) begin errors++; $display("FAIL bp_w7: got %h want 8x11c0", w_log[w0+7]); end
        checks++; if (error_count !== 32'd0) begin errors++; $display("FAIL bp_errcnt: got %0d want 0", error_count); end
    endtask

    task automatic test_errors();
        int r0;
        r0 = ar_log.size();
        bad_b = 0; bad_r_burst = 1; bad_r_beat = 2;
        run_test("errs", 64'h4000, 16'd2, 8'd7);
        bad_b = -1; bad_r_burst = -1; bad_r_beat = -1;
        checks++; if (error_count !== 32'd2) begin errors++; $display("FAIL errs_errcnt: got %0d want 2", error_count); end
        checks++; if (ar_log[r0+1] !== 64'h4200) begin errors++; $display("FAIL errs_ar1: got %h want 4200", ar_log[r0+1]); end
        tick(); tick(); tick(); tick(); tick();
        checks++; if (error_count !== 32'd2) begin errors++; $display("FAIL errs_hold: got %0d want 2", error_count); end
    endtask

    task automatic test_early_last();
        int h0, r0;
        h0 = r_hs_cnt; r0 = ar_log.size();
        early_last = 1;
        run_test("early", 64'h8000, 16'd1, 8'd3);
        early_last = 0;
        checks++; if (error_count !== 32'd2) begin errors++; $display("FAIL early_errcnt: got %0d want 2", error_count); end
        checks++; if (r_hs_cnt - h0 !== 4) begin errors++; $display("FAIL early_beats: got %0d want 4", r_hs_cnt - h0); end
        checks++; if (ar_log.size() - r0 !== 1) begin errors++; $display("FAIL early_ar_count: got %0d want 1", ar_log.size() - r0); end
    endtask

    task automatic test_ignore_start();
        int a0, d0;
        a0 = aw_log.size(); d0 = done_cnt;
        base_addr = 64'h100; burst_count = 16'd2; burst_len = 8'd1; start = 1;
        tick();
        start = 0;
        tick(); tick(); tick();
        base_addr = 64'h9000; burst_count = 16'd7; start = 1;
        tick();
        start = 0;
        wait_done("ign");
        tick(); tick();
        checks++; if (aw_log.size() - a0 !== 2) begin errors++; $display("FAIL ign_aw_count: got %0d want 2", aw_log.size() - a0); end
        checks++; if (aw_log[a0+1] !== 64'h180) begin errors++; $display("FAIL ign_aw1: got %h want 180", aw_log[a0+1]); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ign_done_pulses: got %0d want 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy: got %0b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit hit;
        int a0;
        bad_b = 0;
        base_addr = 64'h1000; burst_count = 16'd2; burst_len = 8'd3; start = 1;
        tick();
        start = 0;
        hit = 0;
        for (int i = 0; i < 500; i++) begin
            if (M_AXI_WVALID && error_count == 32'd1) begin
                hit = 1;
                break;
            end
            tick();
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach_w: got %0b want 1", hit); end
        resetn = 0;
        tick();
        resetn = 1;
        bad_b = -1;
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID} !== 3'b0) begin
            errors++;
            $display("FAIL rstmid_valids: got %b want 000", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID});
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b want 0", busy); end
        checks++; if (error_count !== 32'd0) begin errors++; $display("FAIL rstmid_errcnt: got %0d want 0", error_count); end
        tick();
        a0 = aw_log.size();
        run_test("rstmid_rerun", 64'h3000, 16'd2, 8'd3);
        checks++; if (aw_log.size() - a0 !== 2 || aw_log[a0+1] !== 64'h3100) begin errors++; $display("FAIL rstmid_rerun_aw: got %0d bursts last %h want 2 3100", aw_log.size() - a0, aw_log[a0+1]); end
        checks++; if (error_count !== 32'd0) begin errors++; $display("FAIL rstmid_rerun_errcnt: got %0d want 0", error_count); end
    endtask

    initial begin
        errors = 0; checks = 0;
        start = 0; base_addr = '0; burst_count = '0; burst_len = '0; resetn = 0;
        aw_delay = 0; w_delay = 0; bad_b = -1; bad_r_burst = -1; bad_r_beat = -1; early_last = 0;
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_errors();
        test_early_last();
        test_ignore_start();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
